// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter slice: VRAM widths, grant states
// and a small pointer-width helper used by the write buffer.
package vram_arbiter_pkg;

    // VRAM geometry: 64K pixels of 3-bit RGB colour.
    localparam int unsigned VRAM_ADDR_W  = 16;
    localparam int unsigned VRAM_COLOR_W = 3;

    // What the VRAM port is doing in the cycle after the decision.
    typedef enum logic [1:0] {
        G_IDLE  = 2'd0,
        G_READ  = 2'd1,
        G_WRITE = 2'd2
    } grant_t;

    // Pointer width for a power-of-2 buffer; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of the CPU write path, VGA read path and VRAM port signals.
// slave: the arbiter side; master: the surrounding CPU/VGA/VRAM side.
interface vram_arbiter_if
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = VRAM_ADDR_W,
    parameter int unsigned DATA_W = VRAM_COLOR_W
) ();

    // CPU WVM write path
    logic              iCpuWrReq;
    logic [ADDR_W-1:0] iCpuWrAddr;
    logic [DATA_W-1:0] iCpuWrData;
    logic              oCpuStall;

    // VGA scan-out read path
    logic              iVgaRdReq;
    logic [ADDR_W-1:0] iVgaRdAddr;
    logic [DATA_W-1:0] oVgaRdData;
    logic              oVgaRdValid;
    logic              oVgaMiss;

    // VRAM port
    logic [ADDR_W-1:0] oVramAddr;
    logic [DATA_W-1:0] oVramWrData;
    logic              oVramWe;
    logic              oVramRe;
    logic [DATA_W-1:0] iVramRdData;

    // Status
    logic              oIdle;

    modport slave (
        input  iCpuWrReq, iCpuWrAddr, iCpuWrData,
        input  iVgaRdReq, iVgaRdAddr,
        input  iVramRdData,
        output oCpuStall,
        output oVgaRdData, oVgaRdValid, oVgaMiss,
        output oVramAddr, oVramWrData, oVramWe, oVramRe,
        output oIdle
    );

    modport master (
        output iCpuWrReq, iCpuWrAddr, iCpuWrData,
        output iVgaRdReq, iVgaRdAddr,
        output iVramRdData,
        input  oCpuStall,
        input  oVgaRdData, oVgaRdValid, oVgaMiss,
        input  oVramAddr, oVramWrData, oVramWe, oVramRe,
        input  oIdle
    );

endinterface

// File: rtl/vram_arbiter_sync_fifo.sv
// Single-clock FIFO with occupancy count. DEPTH must be a power of 2 so the
// pointers wrap naturally. Push is ignored when full, pop when empty.
module sync_fifo
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_din,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_dout,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [ptr_width(DEPTH):0]      o_count
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; contents need no reset since the count gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port VRAM between buffered CPU writes and VGA
// scan-out reads. Reads win, except that once the write buffer has sat full
// through STARVE_MAX read grants, one write is forced through.
// The grant is decided combinationally in cycle N and every VRAM-side output
// is registered, so the access appears on the VRAM port in cycle N+1.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = VRAM_ADDR_W,
    parameter int unsigned DATA_W     = VRAM_COLOR_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic           Clock,
    input  logic           Reset,
    vram_arbiter_if.slave  bus
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = ptr_width(FIFO_DEPTH) + 1;
    localparam int unsigned ST_W    = $clog2(STARVE_MAX + 1);

    // Write buffer interface
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_push_entry;
    logic [ENTRY_W-1:0] w_head;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [DATA_W-1:0]  w_head_data;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [CNT_W-1:0]   w_fifo_count;

    // Arbitration
    logic               w_force;
    grant_t             w_grant;

    // Registered state and VRAM-side outputs
    grant_t             r_state;
    logic [ST_W-1:0]    r_starve;
    logic               r_vram_we;
    logic               r_vram_re;
    logic [ADDR_W-1:0]  r_vram_addr;
    logic [DATA_W-1:0]  r_vram_wr_data;
    logic               r_vga_miss;
    logic               r_rd_valid;

    assign w_push       = bus.iCpuWrReq && !w_fifo_full;
    assign w_push_entry = {bus.iCpuWrAddr, bus.iCpuWrData};
    assign w_head_addr  = w_head[ENTRY_W-1:DATA_W];
    assign w_head_data  = w_head[DATA_W-1:0];
    assign w_pop        = (w_grant == G_WRITE);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .i_clk   (Clock),
        .i_rst_n (Reset),
        .i_push  (w_push),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // A full buffer that has been starved long enough overrides VGA priority.
    assign w_force = w_fifo_full && (r_starve == ST_W'(STARVE_MAX));

    // Grant decision for this cycle: forced write, then read, then drain.
    always_comb begin
        w_grant = G_IDLE;
        if (w_force && !w_fifo_empty) begin
            w_grant = G_WRITE;
        end else if (bus.iVgaRdReq) begin
            w_grant = G_READ;
        end else if (!w_fifo_empty) begin
            w_grant = G_WRITE;
        end
    end

    // Grant register, starvation counter and all registered VRAM/VGA outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state        <= G_IDLE;
            r_starve       <= '0;
            r_vram_we      <= 1'b0;
            r_vram_re      <= 1'b0;
            r_vram_addr    <= '0;
            r_vram_wr_data <= '0;
            r_vga_miss     <= 1'b0;
            r_rd_valid     <= 1'b0;
        end else begin
            r_state    <= w_grant;
            r_vram_we  <= (w_grant == G_WRITE);
            r_vram_re  <= (w_grant == G_READ);
            r_vga_miss <= bus.iVgaRdReq && (w_grant != G_READ);
            // VRAM data lands one cycle after the read enable.
            r_rd_valid <= r_vram_re;

            case (w_grant)
                G_READ: begin
                    r_vram_addr <= bus.iVgaRdAddr;
                end
                G_WRITE: begin
                    r_vram_addr    <= w_head_addr;
                    r_vram_wr_data <= w_head_data;
                end
                default: begin
                    r_vram_addr    <= r_vram_addr;
                    r_vram_wr_data <= r_vram_wr_data;
                end
            endcase

            // Only reads granted while the buffer stays full count as starvation.
            if ((w_grant == G_WRITE) || !w_fifo_full) begin
                r_starve <= '0;
            end else if ((w_grant == G_READ) && (r_starve != ST_W'(STARVE_MAX))) begin
                r_starve <= r_starve + ST_W'(1);
            end
        end
    end

    assign bus.oCpuStall   = w_fifo_full;
    assign bus.oVramWe     = r_vram_we;
    assign bus.oVramRe     = r_vram_re;
    assign bus.oVramAddr   = r_vram_addr;
    assign bus.oVramWrData = r_vram_wr_data;
    assign bus.oVgaMiss    = r_vga_miss;
    assign bus.oVgaRdValid = r_rd_valid;
    assign bus.oVgaRdData  = r_rd_valid ? bus.iVramRdData : '0;
    assign bus.oIdle       = (w_fifo_count == '0) && (r_state == G_IDLE);

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a transaction-level reference model queues the
// expected VRAM writes, reads, read data, misses and per-cycle status; a
// monitor on the falling edge pops and compares whatever the DUT presents.
module tb_vram_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SMAX  = 8;

    typedef struct {
        int unsigned cyc;
        logic [15:0] addr;
        logic [2:0]  data;
    } ev_t;

    typedef struct {
        int unsigned cyc;
        logic        stall;
        logic        idle;
    } st_t;

    logic        clk;
    logic        rst_n;
    int unsigned cyc;

    int unsigned nchk;
    int unsigned nerr;

    vram_arbiter_if #(.ADDR_W(16), .DATA_W(3)) bus ();

    vram_arbiter #(
        .ADDR_W     (16),
        .DATA_W     (3),
        .FIFO_DEPTH (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    // Expectation queues (scoreboard)
    ev_t         wr_q [$];
    ev_t         re_q [$];
    ev_t         rdv_q[$];
    int unsigned miss_q[$];
    st_t         st_q [$];

    // Reference model state
    ev_t         mq[$];
    int unsigned starve;
    bit          prev_idle;
    logic [2:0]  model_mem [65536];

    // VRAM behavioural model
    logic [2:0]  vmem [65536];
    logic [2:0]  vram_rd;

    // Monitor-side observations for directed checks
    int unsigned miss_seen;
    logic [2:0]  ord_log[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.oVramWe) vmem[bus.oVramAddr] = bus.oVramWrData;
        if (bus.oVramRe) vram_rd <= vmem[bus.oVramAddr];
    end
    assign bus.iVramRdData = vram_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectations.
    always @(negedge clk) begin
        st_t s;
        ev_t e;
        chk("we_re_exclusive", {31'd0, bus.oVramWe & bus.oVramRe}, 32'd0);
        if (!rst_n) begin
            chk("rst_we",     {31'd0, bus.oVramWe},     32'd0);
            chk("rst_re",     {31'd0, bus.oVramRe},     32'd0);
            chk("rst_addr",   {16'd0, bus.oVramAddr},   32'd0);
            chk("rst_wdata",  {29'd0, bus.oVramWrData}, 32'd0);
            chk("rst_valid",  {31'd0, bus.oVgaRdValid}, 32'd0);
            chk("rst_miss",   {31'd0, bus.oVgaMiss},    32'd0);
        end
        if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
            s = st_q.pop_front();
            chk("stall", {31'd0, bus.oCpuStall}, {31'd0, s.stall});
            chk("idle",  {31'd0, bus.oIdle},     {31'd0, s.idle});
        end
        while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
            e = wr_q.pop_front();
            chk("wr_missing", 32'd0, 32'd1);
        end
        while (re_q.size() > 0 && re_q[0].cyc < cyc) begin
            e = re_q.pop_front();
            chk("re_missing", 32'd0, 32'd1);
        end
        while (rdv_q.size() > 0 && rdv_q[0].cyc < cyc) begin
            e = rdv_q.pop_front();
            chk("rdvalid_missing", 32'd0, 32'd1);
        end
        while (miss_q.size() > 0 && miss_q[0] < cyc) begin
            void'(miss_q.pop_front());
            chk("miss_missing", 32'd0, 32'd1);
        end
        if (bus.oVramWe) begin
            if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
                e = wr_q.pop_front();
                chk("wr_addr", {16'd0, bus.oVramAddr},   {16'd0, e.addr});
                chk("wr_data", {29'd0, bus.oVramWrData}, {29'd0, e.data});
                if (bus.oVramAddr == 16'h0010) ord_log.push_back(bus.oVramWrData);
            end else begin
                chk("unexpected_we", 32'd1, 32'd0);
            end
        end
        if (bus.oVramRe) begin
            if (re_q.size() > 0 && re_q[0].cyc == cyc) begin
                e = re_q.pop_front();
                chk("re_addr", {16'd0, bus.oVramAddr}, {16'd0, e.addr});
            end else begin
                chk("unexpected_re", 32'd1, 32'd0);
            end
        end
        if (bus.oVgaRdValid) begin
            if (rdv_q.size() > 0 && rdv_q[0].cyc == cyc) begin
                e = rdv_q.pop_front();
                chk("rd_data", {29'd0, bus.oVgaRdData}, {29'd0, e.data});
            end else begin
                chk("unexpected_rdvalid", 32'd1, 32'd0);
            end
        end
        if (bus.oVgaMiss) begin
            miss_seen++;
            if (miss_q.size() > 0 && miss_q[0] == cyc) begin
                void'(miss_q.pop_front());
                chk("miss_pulse", 32'd1, 32'd1 & {31'd0, bus.oVgaMiss});
            end else begin
                chk("unexpected_miss", 32'd1, 32'd0);
            end
        end
    end

    // One cycle of stimulus plus the reference model's view of that cycle.
    task automatic step(input bit rst_val, input bit wr, input logic [15:0] wa,
                        input logic [2:0] wd, input bit rd, input logic [15:0] ra,
                        output bit acc);
        bit  full;
        ev_t e;
        @(posedge clk);
        #2;
        rst_n          = rst_val;
        bus.iCpuWrReq  = wr;
        bus.iCpuWrAddr = wa;
        bus.iCpuWrData = wd;
        bus.iVgaRdReq  = rd;
        bus.iVgaRdAddr = ra;
        acc = 1'b0;
        if (!rst_val) begin
            mq.delete();
            wr_q.delete();
            re_q.delete();
            rdv_q.delete();
            miss_q.delete();
            starve    = 0;
            prev_idle = 1'b1;
            st_q.push_back('{cyc: cyc, stall: 1'b0, idle: 1'b1});
            return;
        end
        full = (mq.size() == DEPTH);
        st_q.push_back('{cyc: cyc, stall: full, idle: (mq.size() == 0) && prev_idle});
        if ((full && starve == SMAX) || (!rd && mq.size() != 0)) begin
            e = mq.pop_front();
            model_mem[e.addr] = e.data;
            wr_q.push_back('{cyc: cyc + 1, addr: e.addr, data: e.data});
            if (rd) miss_q.push_back(cyc + 1);
            starve    = 0;
            prev_idle = 1'b0;
        end else if (rd) begin
            re_q.push_back('{cyc: cyc + 1, addr: ra, data: 3'd0});
            rdv_q.push_back('{cyc: cyc + 2, addr: ra, data: model_mem[ra]});
            starve    = full ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
            prev_idle = 1'b0;
        end else begin
            starve    = 0;
            prev_idle = 1'b1;
        end
        if (wr && !full) begin
            mq.push_back('{cyc: 0, addr: wa, data: wd});
            acc = 1'b1;
        end
    endtask

    task automatic idle_steps(input int unsigned n);
        bit acc;
        for (int unsigned i = 0; i < n; i++) step(1'b1, 1'b0, 16'd0, 3'd0, 1'b0, 16'd0, acc);
    endtask

    initial begin
        bit          acc;
        bit          pend;
        logic [15:0] pa;
        logic [2:0]  pd;
        bit          rd;
        int unsigned n;
        logic [2:0]  tmp;

        nchk = 0;
        nerr = 0;
        miss_seen = 0;
        starve = 0;
        prev_idle = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            vmem[i]      = 3'd0;
            model_mem[i] = 3'd0;
        end
        vmem[16'h0123]      = 3'b100;
        model_mem[16'h0123] = 3'b100;

        rst_n          = 1'b0;
        bus.iCpuWrReq  = 1'b1;
        bus.iCpuWrAddr = 16'h0A0A;
        bus.iCpuWrData = 3'd5;
        bus.iVgaRdReq  = 1'b0;
        bus.iVgaRdAddr = 16'd0;

        // Reset held with a write request pending; nothing may leak out afterwards.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0A0A, 3'd5, 1'b0, 16'd0, acc);
        idle_steps(5);

        // Single write with no VGA traffic.
        step(1'b1, 1'b1, 16'h00FF, 3'b010, 1'b0, 16'd0, acc);
        idle_steps(5);

        // Single read: enable after one cycle, data after two.
        step(1'b1, 1'b0, 16'd0, 3'd0, 1'b1, 16'h0123, acc);
        idle_steps(4);

        // Continuous reads while five writes are offered: fill, starve, forced write.
        miss_seen = 0;
        n = 0;
        for (int unsigned i = 0; i < 18; i++) begin
            step(1'b1, n < 5, 16'h0200 + 16'(n), 3'(n + 1), 1'b1, 16'h0300 + 16'(i), acc);
            if (acc) n++;
        end
        idle_steps(8);
        chk("prio_pushes_accepted", n, 32'd5);
        chk("prio_miss_count", miss_seen, 32'd1);

        // Back-to-back writes to one address must land in CPU order.
        ord_log.delete();
        n = 0;
        while (n < 6) begin
            step(1'b1, 1'b1, 16'h0010, 3'(n + 1), 1'b0, 16'd0, acc);
            if (acc) n++;
        end
        idle_steps(6);
        chk("order_final_value", {29'd0, vmem[16'h0010]}, 32'd6);
        chk("order_count", ord_log.size(), 32'd6);
        for (int unsigned i = 0; i < ord_log.size(); i++) begin
            tmp = ord_log[i];
            chk("order_seq", {29'd0, tmp}, i + 1);
        end

        // Reset with three buffered writes and a read in flight.
        for (int unsigned i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h0040 + 16'(i), 3'(i + 3), 1'b1, 16'h0123, acc);
        step(1'b1, 1'b0, 16'd0, 3'd0, 1'b1, 16'h0123, acc);
        step(1'b0, 1'b0, 16'd0, 3'd0, 1'b0, 16'd0, acc);
        step(1'b0, 1'b0, 16'd0, 3'd0, 1'b0, 16'd0, acc);
        idle_steps(6);
        chk("idle_after_reset", {31'd0, bus.oIdle}, 32'd1);

        // Randomised traffic; a stalled write request is held until accepted.
        pend = 1'b0;
        pa = 16'd0;
        pd = 3'd0;
        for (int unsigned i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 1) == 1) begin
                pend = 1'b1;
                pa   = 16'($urandom_range(0, 15));
                pd   = 3'($urandom);
            end
            rd = ($urandom_range(0, 3) != 0);
            step(1'b1, pend, pa, pd, rd, 16'($urandom_range(0, 15)), acc);
            if (acc) pend = 1'b0;
        end
        idle_steps(12);

        chk("wr_q_drained",   wr_q.size(),   32'd0);
        chk("re_q_drained",   re_q.size(),   32'd0);
        chk("rdv_q_drained",  rdv_q.size(),  32'd0);
        chk("miss_q_drained", miss_q.size(), 32'd0);
        chk("final_idle", {31'd0, bus.oIdle}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
